// File: rtl/axi_mst_write.sv
// Write-direction DDR bandwidth engine: AXI-Stream -> 16-deep FIFO -> NBURST_REG INCR bursts; AXI_MST_WRITE_RESP_CHECK_EN counts bad bresp.
// Latency: AW issues 3 cycles after START_REG when a full burst is already buffered; 3-cycle gap between bursts.
// Backpressure: s_axis_tready drops on a registered FIFO-full flag; AW/W/B obey valid-ready, one burst in flight.
module axi_mst_write #(
  parameter int ID_WIDTH       = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int BURST_LENGTH   = 7,
  parameter int B_BURST_LENGTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [31:0]               m_axi_awaddr,
  output logic [B_BURST_LENGTH-1:0] m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic [1:0]                m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [ID_WIDTH-1:0]       m_axi_wid,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic                      s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  output logic                      s_axis_tready,
  input  logic                      START_REG,
  input  logic [31:0]               ADDR_REG,
  input  logic [31:0]               NBURST_REG,
  output logic                      DONE_REG,
  output logic [31:0]               ERR_REG
);

  localparam int          STRB_W      = DATA_WIDTH / 8;
  localparam logic [31:0] ADDR_STEP   = 32'((BURST_LENGTH + 1) * STRB_W);
  localparam logic [2:0]  AW_SIZE     = 3'($clog2(STRB_W));
  localparam logic [4:0]  BURST_WORDS = 5'(BURST_LENGTH + 1);
  localparam logic [3:0]  LAST_BEAT   = 4'(BURST_LENGTH);

  typedef enum logic [9:0] {
    INIT_ST      = 10'h001,
    START_ST     = 10'h002,
    READ_REGS_ST = 10'h004,
    WAIT_DATA_ST = 10'h008,
    ADDR_ST      = 10'h010,
    DATA_ST      = 10'h020,
    RESP_ST      = 10'h040,
    NBURST_ST    = 10'h080,
    INCR_ADDR_ST = 10'h100,
    END_ST       = 10'h200
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] nburst_q, nburst_d;
  logic [31:0] burst_cnt_q, burst_cnt_d;
  logic [3:0]  beat_q, beat_d;
`ifdef AXI_MST_WRITE_RESP_CHECK_EN
  logic [31:0] err_q, err_d;
`endif

  logic [DATA_WIDTH-1:0] mem_q [16];
  logic [3:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]            count_q, count_d;
  logic                  full_q, full_d;
  logic                  push, pop, fifo_empty;

  assign s_axis_tready = ~full_q;
  assign fifo_empty    = (count_q == 5'd0);
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axi_wvalid & m_axi_wready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 4'd1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 4'd1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 5'd1;
    end else if (pop && !push) begin
      count_d = count_q - 5'd1;
    end
    // Registered so tready never depends on the same-cycle pop.
    full_d = (count_d == 5'd16);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    nburst_d      = nburst_q;
    burst_cnt_d   = burst_cnt_q;
    beat_d        = beat_q;
`ifdef AXI_MST_WRITE_RESP_CHECK_EN
    err_d         = err_q;
`endif
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    unique case (state_q)
      INIT_ST: state_d = START_ST;
      START_ST: begin
        if (START_REG) state_d = READ_REGS_ST;
      end
      READ_REGS_ST: begin
        addr_d      = ADDR_REG;
        nburst_d    = NBURST_REG;
        burst_cnt_d = '0;
        beat_d      = '0;
`ifdef AXI_MST_WRITE_RESP_CHECK_EN
        err_d       = '0;
`endif
        state_d     = (NBURST_REG == 32'd0) ? END_ST : WAIT_DATA_ST;
      end
      WAIT_DATA_ST: begin
        // Whole burst must be buffered so wvalid never gaps once AW is out.
        if (count_q >= BURST_WORDS) state_d = ADDR_ST;
      end
      ADDR_ST: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = DATA_ST;
      end
      DATA_ST: begin
        m_axi_wvalid = ~fifo_empty;
        if (!fifo_empty && m_axi_wready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = RESP_ST;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      RESP_ST: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          burst_cnt_d = burst_cnt_q + 32'd1;
          state_d     = NBURST_ST;
`ifdef AXI_MST_WRITE_RESP_CHECK_EN
          if (m_axi_bresp != 2'b00 && err_q != 32'hFFFF_FFFF) err_d = err_q + 32'd1;
`endif
        end
      end
      NBURST_ST: state_d = (burst_cnt_q == nburst_q) ? END_ST : INCR_ADDR_ST;
      INCR_ADDR_ST: begin
        addr_d  = addr_q + ADDR_STEP;
        state_d = WAIT_DATA_ST;
      end
      END_ST: begin
        if (!START_REG) state_d = START_ST;
      end
      default: state_d = INIT_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_ST;
      addr_q      <= '0;
      nburst_q    <= '0;
      burst_cnt_q <= '0;
      beat_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
`ifdef AXI_MST_WRITE_RESP_CHECK_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      nburst_q    <= nburst_d;
      burst_cnt_q <= burst_cnt_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
`ifdef AXI_MST_WRITE_RESP_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = B_BURST_LENGTH'(BURST_LENGTH);
  assign m_axi_awsize  = AW_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = '0;
  assign m_axi_awcache = '0;
  assign m_axi_awprot  = '0;
  assign m_axi_awqos   = '0;
  assign m_axi_wid     = '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = m_axi_wvalid ? mem_q[rd_ptr_q] : '0;
  assign m_axi_wlast   = (state_q == DATA_ST) && (beat_q == LAST_BEAT);
  assign DONE_REG      = (state_q == END_ST);

  logic unused_inputs;
`ifdef AXI_MST_WRITE_RESP_CHECK_EN
  assign ERR_REG       = err_q;
  assign unused_inputs = ^m_axi_bid;
`else
  assign ERR_REG       = '0;
  assign unused_inputs = ^{m_axi_bid, m_axi_bresp};
`endif

endmodule

// File: tb/tb_axi_mst_write.sv
// Directed bench for axi_mst_write: vector table of burst jobs plus hand sequences for
// partial data, FIFO-full backpressure, NBURST=0 timing and mid-burst reset.
module tb_axi_mst_write;

`ifdef AXI_MST_WRITE_RESP_CHECK_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  m_axi_awid, m_axi_wid;
  logic [31:0] m_axi_awaddr;
  logic [3:0]  m_axi_awlen, m_axi_awcache, m_axi_awqos;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst, m_axi_awlock;
  logic        m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic [5:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        s_axis_tvalid = 1'b0, s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic        START_REG = 1'b0, DONE_REG;
  logic [31:0] ADDR_REG = '0, NBURST_REG = '0, ERR_REG;

  axi_mst_write dut (
    .clk(clk), .rst(rst),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .START_REG(START_REG), .ADDR_REG(ADDR_REG), .NBURST_REG(NBURST_REG),
    .DONE_REG(DONE_REG), .ERR_REG(ERR_REG)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory-side and stream-side model state
  logic [63:0] stream_q[$];
  logic [31:0] aw_log[$];
  logic [63:0] w_log[$];
  bit          wl_log[$];
  bit          bp_en   = 1'b0;
  bit          hold_w  = 1'b0;
  int          err_burst = -1;
  int          b_pend  = 0;
  int          b_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (stream_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = stream_q[0];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
    end
    m_axi_awready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_wready  = hold_w ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
    if (b_pend > 0 && (!bp_en || $urandom_range(0, 1) == 1)) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
    end else begin
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
    end
    #1;
    if (!rst) begin
      if (s_axis_tvalid && s_axis_tready) void'(stream_q.pop_front());
      if (m_axi_awvalid && m_axi_awready) aw_log.push_back(m_axi_awaddr);
      if (m_axi_wvalid && m_axi_wready) begin
        w_log.push_back(m_axi_wdata);
        wl_log.push_back(m_axi_wlast);
        if (m_axi_wlast) b_pend++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend--;
        b_count++;
      end
    end
  end

  task automatic clear_logs();
    aw_log.delete();
    w_log.delete();
    wl_log.delete();
    b_count = 0;
    b_pend  = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (DONE_REG !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done timeout"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic start_job(input logic [31:0] addr, input logic [31:0] nb);
    @(negedge clk);
    ADDR_REG   = addr;
    NBURST_REG = nb;
    START_REG  = 1'b1;
  endtask

  task automatic drop_start(input string tag);
    START_REG = 1'b0;
    @(negedge clk);
    check({tag, " back to START"}, 64'(DONE_REG), 64'd0);
  endtask

  // Compare logged beats against consecutive words from base, wlast every 8th beat.
  task automatic check_beats(input string tag, input int nbeats, input logic [63:0] base);
    int bad = 0;
    check({tag, " beat count"}, 64'(w_log.size()), 64'(nbeats));
    for (int i = 0; i < w_log.size() && i < nbeats; i++) begin
      if (w_log[i] !== base + 64'(i)) bad++;
      if (wl_log[i] !== ((i % 8) == 7)) bad++;
    end
    check({tag, " data/wlast errors"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [31:0] nburst;
    logic [31:0] addr;
    int          nwords;
    bit          bp;
    int          errb;
    int          exp_aw;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'd1, 32'h1000_0000, 8,  1'b0, -1, 1, 32'h1000_0000, 32'd0};
    vecs[1] = '{32'd4, 32'h2000_0000, 32, 1'b0, -1, 4, 32'h2000_00C0, 32'd0};
    vecs[2] = '{32'd3, 32'h3000_0000, 24, 1'b1, 1,  3, 32'h3000_0080, 32'(ERR_EN)};
    vecs[3] = '{32'd2, 32'hFFFF_FFC0, 16, 1'b1, -1, 2, 32'h0000_0000, 32'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst wvalid", 64'(m_axi_wvalid), 64'd0);
    check("rst bready", 64'(m_axi_bready), 64'd0);
    check("rst tready", 64'(s_axis_tready), 64'd1);
    check("rst done", 64'(DONE_REG), 64'd0);
    check("rst err", 64'(ERR_REG), 64'd0);
    check("awlen", 64'(m_axi_awlen), 64'd7);
    check("awsize", 64'(m_axi_awsize), 64'd3);
    check("awburst", 64'(m_axi_awburst), 64'd1);
    check("wstrb", 64'(m_axi_wstrb), 64'hFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      string tag;
      int    bad;
      tag = $sformatf("vec%0d", v);
      clear_logs();
      bp_en     = vecs[v].bp;
      err_burst = vecs[v].errb;
      for (int i = 0; i < vecs[v].nwords; i++) stream_q.push_back((64'(v) << 8) + 64'(i));
      start_job(vecs[v].addr, vecs[v].nburst);
      wait_done(tag);
      check({tag, " aw count"}, 64'(aw_log.size()), 64'(vecs[v].exp_aw));
      if (aw_log.size() > 0)
        check({tag, " last awaddr"}, 64'(aw_log[aw_log.size()-1]), 64'(vecs[v].exp_last_addr));
      bad = 0;
      for (int i = 0; i < aw_log.size(); i++)
        if (aw_log[i] !== vecs[v].addr + 32'(i * 64)) bad++;
      check({tag, " awaddr sequence errors"}, 64'(bad), 64'd0);
      check_beats(tag, vecs[v].exp_aw * 8, 64'(v) << 8);
      check({tag, " err"}, 64'(ERR_REG), 64'(vecs[v].exp_err));
      drop_start(tag);
    end
    bp_en     = 1'b0;
    err_burst = -1;

    // NBURST=0: DONE two cycles after START, no bus activity
    clear_logs();
    start_job(32'h4000_0000, 32'd0);
    @(negedge clk);
    check("nb0 done after 1", 64'(DONE_REG), 64'd0);
    @(negedge clk);
    check("nb0 done after 2", 64'(DONE_REG), 64'd1);
    check("nb0 no aw", 64'(aw_log.size()), 64'd0);
    drop_start("nb0");

    // Only 5 of 8 words buffered: AW must wait
    clear_logs();
    for (int i = 0; i < 5; i++) stream_q.push_back(64'hD00 + 64'(i));
    start_job(32'h5000_0000, 32'd1);
    repeat (20) @(negedge clk);
    check("partial awvalid", 64'(m_axi_awvalid), 64'd0);
    check("partial no aw", 64'(aw_log.size()), 64'd0);
    for (int i = 5; i < 8; i++) stream_q.push_back(64'hD00 + 64'(i));
    wait_done("partial");
    check("partial aw count", 64'(aw_log.size()), 64'd1);
    check_beats("partial", 8, 64'hD00);
    drop_start("partial");

    // FIFO fills to 16 while idle, then two bursts drain it under random backpressure
    clear_logs();
    for (int i = 0; i < 20; i++) stream_q.push_back(64'hE00 + 64'(i));
    repeat (30) @(negedge clk);
    check("full tready", 64'(s_axis_tready), 64'd0);
    check("full words left", 64'(stream_q.size()), 64'd4);
    bp_en = 1'b1;
    begin
      int k = 0;
      start_job(32'h6000_0000, 32'd2);
      while (m_axi_awvalid !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("start to awvalid", 64'(k), 64'd3);
    end
    wait_done("full");
    check("full aw count", 64'(aw_log.size()), 64'd2);
    if (aw_log.size() == 2) check("full aw2 addr", 64'(aw_log[1]), 64'h6000_0040);
    check_beats("full", 16, 64'hE00);
    check("full rest accepted", 64'(stream_q.size()), 64'd0);
    drop_start("full");
    clear_logs();
    bp_en = 1'b0;
    for (int i = 20; i < 24; i++) stream_q.push_back(64'hE00 + 64'(i));
    start_job(32'h6000_1000, 32'd1);
    wait_done("retained");
    check_beats("retained", 8, 64'hE10);
    drop_start("retained");

    // Reset while a burst is stuck in DATA
    clear_logs();
    hold_w = 1'b1;
    for (int i = 0; i < 8; i++) stream_q.push_back(64'hF00 + 64'(i));
    begin
      int k = 0;
      start_job(32'h7000_0000, 32'd1);
      while (m_axi_wvalid !== 1'b1 && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("mid reset reached DATA", 64'(m_axi_wvalid), 64'd1);
    end
    rst       = 1'b1;
    START_REG = 1'b0;
    @(negedge clk);
    check("mid rst awvalid", 64'(m_axi_awvalid), 64'd0);
    check("mid rst wvalid", 64'(m_axi_wvalid), 64'd0);
    check("mid rst wlast", 64'(m_axi_wlast), 64'd0);
    check("mid rst wdata", m_axi_wdata, 64'd0);
    check("mid rst bready", 64'(m_axi_bready), 64'd0);
    check("mid rst awaddr", 64'(m_axi_awaddr), 64'd0);
    check("mid rst tready", 64'(s_axis_tready), 64'd1);
    check("mid rst done", 64'(DONE_REG), 64'd0);
    check("mid rst err", 64'(ERR_REG), 64'd0);
    rst    = 1'b0;
    hold_w = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_mst_write.md
# axi_mst_write

Write-direction DDR bandwidth engine. Accepts an AXI-Stream of DATA_WIDTH words into a 16-deep internal FIFO and writes it to memory as NBURST_REG consecutive INCR bursts through an AXI3-style master port. Sits beside the read engine on the same PS DDR port, driven by the same START/DONE register handshake.

## Interface
- ID_WIDTH, 6, AXI ID width.
- DATA_WIDTH, 64, AXI/AXIS data width; must be 8..1024, power of two.
- BURST_LENGTH, 7, beats per burst minus 1; must be ≤ 15.
- B_BURST_LENGTH, 4, width of m_axi_awlen.

- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- m_axi_awid  out  ID_WIDTH  constant 0.
- m_axi_awaddr  out  32  current burst address.
- m_axi_awlen  out  B_BURST_LENGTH  constant BURST_LENGTH.
- m_axi_awsize  out  3  log2(DATA_WIDTH/8).
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awlock  out  2  constant 0.
- m_axi_awcache  out  4  constant 0.
- m_axi_awprot  out  3  constant 0.
- m_axi_awqos  out  4  constant 0.
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wid  out  ID_WIDTH  constant 0.
- m_axi_wdata  out  DATA_WIDTH  FIFO head.
- m_axi_wstrb  out  DATA_WIDTH/8  all ones.
- m_axi_wlast  out  1  last beat of burst.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bid  in  ID_WIDTH  ignored.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tready  out  1  = ~fifo_full.
- START_REG  in  1  level start.
- ADDR_REG  in  32  base address.
- NBURST_REG  in  32  number of bursts.
- DONE_REG  out  1  high in END_ST.
- ERR_REG  out  32  count of non-OKAY responses.

## Operation
- FIFO: 16 entries, push on s_axis_tvalid & s_axis_tready, pop on m_axi_wvalid & m_axi_wready; 5-bit occupancy count. Stream accepted in any state.
- FSM (one-hot): INIT → START. START: START_REG=1 → READ_REGS. READ_REGS: latch ADDR_REG, NBURST_REG, clear burst counter; NBURST_REG=0 → END, else → WAIT_DATA. WAIT_DATA: occupancy ≥ BURST_LENGTH+1 → ADDR. ADDR: awvalid=1; awready → DATA. DATA: wvalid=~fifo_empty, beat counter 0..BURST_LENGTH, wlast when counter=BURST_LENGTH; wlast beat accepted → RESP. RESP: bready=1; bvalid → NBURST, burst counter +1. NBURST: counter = latched NBURST → END, else → INCR_ADDR. INCR_ADDR: addr += (BURST_LENGTH+1)·DATA_WIDTH/8, mod 2^32 → WAIT_DATA. END: START_REG=0 → START.
- Address issued only after a full burst is buffered, so wvalid never drops mid-burst.
- No outstanding-transaction overlap: one burst in flight.
- START_REG changes outside START/END ignored; NBURST_REG/ADDR_REG sampled only in READ_REGS.

## Timing
- Reset: every output 0 except constants and s_axis_tready=1; FIFO flushed, counters 0, ERR_REG 0, state INIT. Reset mid-burst abandons the transaction (system-wide reset assumed on the interconnect).
- START_REG rise to awvalid: ≥3 cycles (START, READ_REGS, WAIT_DATA) when FIFO already holds a burst.
- awvalid held until awready; awaddr stable while awvalid.
- wdata/wlast stable while wvalid & ~wready.
- Burst-to-burst gap with all ready: NBURST, INCR_ADDR, WAIT_DATA = 3 cycles after bvalid.
- FIFO full + simultaneous pop: tready stays 0 that cycle (registered full flag); simultaneous push and pop keeps occupancy.
- DONE_REG rises the cycle after the final bvalid+1 (NBURST → END).

## Configuration
- AXI_MST_WRITE_RESP_CHECK_EN defined: in RESP, bvalid with bresp≠2'b00 increments ERR_REG (saturating at 2^32−1); ERR_REG cleared in READ_REGS.
- Not defined: ERR_REG tied 0, bresp ignored; no other behaviour changes.

## Test plan
- NBURST=1, ADDR=0x1000_0000, 8 words 0..7 streamed, all readies 1 → one AW at 0x1000_0000 len 7 size 3, W beats 0..7 with wlast on beat 7, DONE_REG=1.
- NBURST=4, ADDR=0x2000_0000 → awaddr 0x2000_0000, 0x40, 0x80, 0xC0 offsets; DONE after 4th bvalid; drop START → START state.
- Stream only 5 words, NBURST=1 → awvalid stays 0; send 3 more → burst issues.
- Random wready/awready/bvalid backpressure, 20 words streamed continuously → tready drops at 16 buffered, no data lost or reordered, 2 complete bursts plus 4 words retained.
- NBURST=0 → no AW/W activity, DONE_REG=1 two cycles after START_REG.
- With RESP_CHECK_EN, bresp=2'b10 on burst 2 of 3 → ERR_REG=1, still completes; rst=1 during DATA → all outputs to reset values next cycle.
